// File: rtl/mips_mc_pkg.sv
// +------------------------------------------------------------------+
// | mips_mc_pkg: states, opcodes and control encodings for the MIPS  |
// | multicycle sequencer.                 Revision: 1.0              |
// +------------------------------------------------------------------+
`default_nettype none

package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  // A store only completes once memory acknowledges it.
  function automatic logic is_retire(input state_t s, input logic mem_ready);
    case (s)
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: is_retire = 1'b1;
      S_MEMWR:                                      is_retire = mem_ready;
      default:                                      is_retire = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_out_decode.sv
// +------------------------------------------------------------------+
// | mc_out_decode: combinational state-to-control-word decoder.      |
// |                                       Revision: 1.0              |
// +------------------------------------------------------------------+
`default_nettype none

module mc_out_decode
  import mips_mc_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       mem_req,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write
);

  always_comb begin
    mem_req    = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_src     = PCSRC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REGB;
    alu_op     = ALUOP_ADD;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    case (state_t'(state))
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE: alu_src_b = SRCB_IMM2;
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_en     = zero;
      end
      S_JUMP: begin
        pc_src = PCSRC_JUMP;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mips_mc_ctrl.sv
// +------------------------------------------------------------------+
// | mips_mc_ctrl: multicycle MIPS control sequencer with memory      |
// | handshake and retired-instruction counter.   Revision: 1.0       |
// +------------------------------------------------------------------+
`default_nettype none

module mips_mc_ctrl
  import mips_mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             iord,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_en,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             illegal_op,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_count
);

  state_t           state_q, state_d;
  logic             illegal_op_q, illegal_op_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;

  logic w_mem_req, w_mem_write, w_ir_write, w_pc_en, w_reg_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      illegal_op_q  <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      illegal_op_q  <= illegal_op_d;
      instr_count_q <= instr_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    illegal_op_d  = illegal_op_q;
    instr_count_d = instr_count_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d      = S_FETCH;
            illegal_op_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
    if (is_retire(state_q, mem_ready) && (instr_count_q != '1))
      instr_count_d = instr_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  mc_out_decode u_dec (
    .state      (state_q),
    .mem_ready  (mem_ready),
    .zero       (zero),
    .mem_req    (w_mem_req),
    .iord       (iord),
    .mem_write  (w_mem_write),
    .ir_write   (w_ir_write),
    .pc_en      (w_pc_en),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (w_reg_write)
  );

  // Enables are held off for the whole reset window, whatever the state.
  assign mem_req     = w_mem_req   & ~rst;
  assign mem_write   = w_mem_write & ~rst;
  assign ir_write    = w_ir_write  & ~rst;
  assign pc_en       = w_pc_en     & ~rst;
  assign reg_write   = w_reg_write & ~rst;
  assign illegal_op  = illegal_op_q;
  assign state_o     = state_q;
  assign instr_count = instr_count_q;

endmodule

`default_nettype wire

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multicycle control sequencer for the MIPS datapath, replacing single-cycle decode so instruction memory, data memory, ALU and register file can be shared across steps of one instruction. It sits beside the CPU datapath inside `MIPS`, takes the opcode and the ALU zero flag, and drives every datapath enable and mux select. It also handshakes with a shared, variable-latency memory and counts retired instructions.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `op`  in  6  opcode field `IR[31:26]`; valid from the DECODE state on.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory access request.
- `iord`  out  1  address select: 0 = PC, 1 = ALUOut.
- `mem_write`  out  1  store strobe.
- `ir_write`  out  1  instruction register load.
- `pc_en`  out  1  PC load.
- `pc_src`  out  2  PC select: 00 = ALU, 01 = ALUOut, 10 = jump target.
- `alu_src_a`  out  1  ALU A select: 0 = PC, 1 = register A.
- `alu_src_b`  out  2  ALU B select: 00 = register B, 01 = 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate.
- `alu_op`  out  2  ALU op: 00 = add, 01 = sub, 10 = funct-decoded.
- `reg_dst`  out  1  destination register: 0 = rt, 1 = rd.
- `mem_to_reg`  out  1  write-back source: 0 = ALUOut, 1 = memory data.
- `reg_write`  out  1  register file write enable.
- `illegal_op`  out  1  sticky flag for an unsupported opcode.
- `state_o`  out  4  current state encoding, for debug.
- `instr_count`  out  `CNT_W`  number of retired instructions.

## Operation
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Encodings 12–15 are unreachable and return to FETCH.
- Outputs are decoded from the state. Any output not listed for a state is 0.
  - FETCH: `mem_req`=1, `alu_src_b`=01. `ir_write` and `pc_en` are 1 only in the cycle where `mem_ready`=1.
  - DECODE: `alu_src_b`=11.
  - MEMADR, ADDIEX: `alu_src_a`=1, `alu_src_b`=10.
  - MEMRD: `mem_req`=1, `iord`=1.
  - MEMWR: `mem_req`=1, `iord`=1, `mem_write`=1.
  - MEMWB: `reg_write`=1, `mem_to_reg`=1.
  - EXECUTE: `alu_src_a`=1, `alu_op`=10.
  - ALUWB: `reg_write`=1, `reg_dst`=1.
  - ADDIWB: `reg_write`=1.
  - BRANCH: `alu_src_a`=1, `alu_op`=01, `pc_src`=01, `pc_en`=`zero`.
  - JUMP: `pc_src`=10, `pc_en`=1.
- Transitions:
  - FETCH→DECODE when `mem_ready`; otherwise stay in FETCH.
  - DECODE dispatches on `op`: 0x23 or 0x2B→MEMADR, 0x00→EXECUTE, 0x04→BRANCH, 0x08→ADDIEX, 0x02→JUMP, any other→FETCH.
  - MEMADR→MEMRD for 0x23, →MEMWR for 0x2B.
  - MEMRD→MEMWB when `mem_ready`; otherwise stay.
  - MEMWR→FETCH when `mem_ready`; otherwise stay.
  - EXECUTE→ALUWB; ADDIEX→ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP→FETCH.
- An unsupported opcode in DECODE sets `illegal_op` on the next edge. The flag stays set until `rst`, and the instruction does not retire.
- `instr_count` increments on every edge leaving MEMWB, ALUWB, ADDIWB, BRANCH or JUMP, and on the edge leaving MEMWR with `mem_ready`=1. It saturates at all-ones.
- `mem_ready` is ignored in states that do not assert `mem_req`.

## Timing
- Reset:
  - `rst` sampled high: state becomes FETCH, `illegal_op`=0, `instr_count`=0.
  - While `rst`=1, all enables (`pc_en`, `ir_write`, `mem_req`, `mem_write`, `reg_write`) are forced to 0.
  - The first FETCH request goes out in the first cycle after `rst` falls.
  - Reset mid-instruction abandons that instruction with no write-back.
- Latency with zero wait (`mem_ready` held at 1): beq and j take 3 cycles; R-type, addi and sw take 4; lw takes 5. Each memory wait cycle adds 1.
- Handshake: `mem_req` stays high and the address and data selects stay stable until the `mem_ready` cycle, inclusive. Consecutive requests may be back-to-back.
- Fully synchronous state, flag and counter; outputs are combinational decode of the state plus `mem_ready` and `zero`.

## Structure
- Package `mips_mc_pkg`: state encodings, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), and the ALUOp and PCSrc encodings.
- Natural sub-module: `mc_out_decode`, the combinational state-to-control-word decoder, shared with the debug display logic.
- The funct-level ALU decoder stays outside this block.

## Test plan
- Reset then `op`=0x00, `mem_ready`=1 → `state_o` sequence 0,1,6,7,0; `reg_write`=1 with `reg_dst`=1 in cycle 4; `instr_count`=1.
- `op`=0x23, `mem_ready` low for 2 cycles in MEMRD → state 3 held 3 cycles with `iord`=1 and `mem_req`=1; lw completes in 7 cycles; `instr_count`=1.
- `op`=0x04 with `zero`=1, then with `zero`=0 → `pc_en`=1 with `pc_src`=01 in the BRANCH cycle for the first, `pc_en`=0 for the second; each takes 3 cycles.
- `op`=0x3F → DECODE returns to FETCH, `illegal_op`=1 from the next edge onward, `instr_count` unchanged; only `rst` clears the flag.
- `rst` asserted in state 5 (MEMWR) → no further `mem_write` pulse, `state_o`=0, `instr_count`=0, first `mem_req` in the cycle after release.
- `CNT_W`=4 with 17 j instructions → `instr_count` saturates at 15.
